// File: rtl/l2dr_req_arbiter.sv
// Merges L2 and L2TLB requests onto the single directory request channel
// (round-robin, nid[0] tags the source) and routes directory snacks by nid[0].
`timescale 1ns/1ps
module l2dr_req_arbiter #(
  parameter logic RR_INIT = 1'b0,
  parameter int   REQ_W   = 49,
  parameter int   SNACK_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l2todr_req_l2_valid,
  output logic               l2todr_req_l2_retry,
  input  logic [REQ_W-1:0]   l2todr_req_l2,
  input  logic               l2todr_req_tlb_valid,
  output logic               l2todr_req_tlb_retry,
  input  logic [REQ_W-1:0]   l2todr_req_tlb,
  output logic               l2todr_req_valid,
  input  logic               l2todr_req_retry,
  output logic [REQ_W-1:0]   l2todr_req,
  input  logic               drtol2_snack_valid,
  output logic               drtol2_snack_retry,
  input  logic [SNACK_W-1:0] drtol2_snack,
  output logic               drtol2_snack_l2_valid,
  input  logic               drtol2_snack_l2_retry,
  output logic [SNACK_W-1:0] drtol2_snack_l2,
  output logic               drtol2_snack_tlb_valid,
  input  logic               drtol2_snack_tlb_retry,
  output logic [SNACK_W-1:0] drtol2_snack_tlb
);

  localparam logic [1:0] QFULL = 2'd2;

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} sel_state_e;

  // ---------------- QL2 ----------------
  logic [REQ_W-1:0] ql2_mem_q [2];
  logic [1:0]       ql2_cnt_q, ql2_cnt_d;
  logic             ql2_wp_q, ql2_rp_q, ql2_retry_q;
  logic             ql2_enq_s, ql2_pop_s, ql2_ne_s;
  logic [REQ_W-1:0] ql2_wdata_s;

  // ---------------- QTLB ---------------
  logic [REQ_W-1:0] qtlb_mem_q [2];
  logic [1:0]       qtlb_cnt_q, qtlb_cnt_d;
  logic             qtlb_wp_q, qtlb_rp_q, qtlb_retry_q;
  logic             qtlb_enq_s, qtlb_pop_s, qtlb_ne_s;
  logic [REQ_W-1:0] qtlb_wdata_s;

  // ---------------- snack queue --------
  logic [SNACK_W-1:0] sq_mem_q [2];
  logic [1:0]         sq_cnt_q, sq_cnt_d;
  logic               sq_wp_q, sq_rp_q, sq_retry_q;
  logic               sq_enq_s, sq_pop_s, sq_ne_s;
  logic [SNACK_W-1:0] sq_head_s;

  // ---------------- selection ----------
  sel_state_e state_q, state_d;
  logic       sel_q, sel_d, last_q, last_d, sel_s;
  logic       req_valid_s, req_xfer_s;

  // Retry is a flop, so accepting is only a function of registered state.
  assign ql2_enq_s  = l2todr_req_l2_valid  & ~ql2_retry_q;
  assign qtlb_enq_s = l2todr_req_tlb_valid & ~qtlb_retry_q;
  assign sq_enq_s   = drtol2_snack_valid   & ~sq_retry_q;

  assign ql2_ne_s  = (ql2_cnt_q  != 2'd0);
  assign qtlb_ne_s = (qtlb_cnt_q != 2'd0);
  assign sq_ne_s   = (sq_cnt_q   != 2'd0);

  // Source tag overwrite on the way in.
  always_comb begin
    ql2_wdata_s     = l2todr_req_l2;
    ql2_wdata_s[0]  = 1'b0;
    qtlb_wdata_s    = l2todr_req_tlb;
    qtlb_wdata_s[0] = 1'b1;
  end

  // Next-state occupancy for the three queues.
  always_comb begin
    case ({ql2_enq_s, ql2_pop_s})
      2'b10:   ql2_cnt_d = ql2_cnt_q + 2'd1;
      2'b01:   ql2_cnt_d = ql2_cnt_q - 2'd1;
      default: ql2_cnt_d = ql2_cnt_q;
    endcase
    case ({qtlb_enq_s, qtlb_pop_s})
      2'b10:   qtlb_cnt_d = qtlb_cnt_q + 2'd1;
      2'b01:   qtlb_cnt_d = qtlb_cnt_q - 2'd1;
      default: qtlb_cnt_d = qtlb_cnt_q;
    endcase
    case ({sq_enq_s, sq_pop_s})
      2'b10:   sq_cnt_d = sq_cnt_q + 2'd1;
      2'b01:   sq_cnt_d = sq_cnt_q - 2'd1;
      default: sq_cnt_d = sq_cnt_q;
    endcase
  end

  // QL2 storage, pointers, count and registered retry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ql2_mem_q[0] <= {REQ_W{1'b0}};
      ql2_mem_q[1] <= {REQ_W{1'b0}};
      ql2_cnt_q    <= 2'd0;
      ql2_wp_q     <= 1'b0;
      ql2_rp_q     <= 1'b0;
      ql2_retry_q  <= 1'b1;
    end else begin
      if (ql2_enq_s) begin
        ql2_mem_q[ql2_wp_q] <= ql2_wdata_s;
        ql2_wp_q            <= ~ql2_wp_q;
      end
      if (ql2_pop_s) begin
        ql2_rp_q <= ~ql2_rp_q;
      end
      ql2_cnt_q   <= ql2_cnt_d;
      ql2_retry_q <= (ql2_cnt_d == QFULL);
    end
  end

  // QTLB storage, pointers, count and registered retry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qtlb_mem_q[0] <= {REQ_W{1'b0}};
      qtlb_mem_q[1] <= {REQ_W{1'b0}};
      qtlb_cnt_q    <= 2'd0;
      qtlb_wp_q     <= 1'b0;
      qtlb_rp_q     <= 1'b0;
      qtlb_retry_q  <= 1'b1;
    end else begin
      if (qtlb_enq_s) begin
        qtlb_mem_q[qtlb_wp_q] <= qtlb_wdata_s;
        qtlb_wp_q             <= ~qtlb_wp_q;
      end
      if (qtlb_pop_s) begin
        qtlb_rp_q <= ~qtlb_rp_q;
      end
      qtlb_cnt_q   <= qtlb_cnt_d;
      qtlb_retry_q <= (qtlb_cnt_d == QFULL);
    end
  end

  // Selection: round-robin while OPEN, frozen once the directory retries.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    sel_s   = 1'b0;
    case (state_q)
      ST_OPEN: begin
        if (ql2_ne_s && qtlb_ne_s) begin
          sel_s = ~last_q;
        end else if (qtlb_ne_s) begin
          sel_s = 1'b1;
        end else begin
          sel_s = 1'b0;
        end
        if (req_valid_s && l2todr_req_retry) begin
          state_d = ST_LOCKED;
          sel_d   = sel_s;
        end else if (req_xfer_s) begin
          last_d = sel_s;
        end else begin
          last_d = last_q;
        end
      end
      ST_LOCKED: begin
        sel_s = sel_q;
        if (req_xfer_s) begin
          state_d = ST_OPEN;
          last_d  = sel_q;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_OPEN;
        sel_s   = 1'b0;
      end
    endcase
  end

  // Selection state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OPEN;
      sel_q   <= 1'b0;
      last_q  <= RR_INIT;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign req_valid_s = ql2_ne_s | qtlb_ne_s;
  assign req_xfer_s  = req_valid_s & ~l2todr_req_retry;
  assign ql2_pop_s   = req_xfer_s & ~sel_s;
  assign qtlb_pop_s  = req_xfer_s &  sel_s;

  assign l2todr_req_valid     = req_valid_s;
  assign l2todr_req           = sel_s ? qtlb_mem_q[qtlb_rp_q] : ql2_mem_q[ql2_rp_q];
  assign l2todr_req_l2_retry  = ql2_retry_q;
  assign l2todr_req_tlb_retry = qtlb_retry_q;

  // Snack queue storage, pointers, count and registered retry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_mem_q[0] <= {SNACK_W{1'b0}};
      sq_mem_q[1] <= {SNACK_W{1'b0}};
      sq_cnt_q    <= 2'd0;
      sq_wp_q     <= 1'b0;
      sq_rp_q     <= 1'b0;
      sq_retry_q  <= 1'b1;
    end else begin
      if (sq_enq_s) begin
        sq_mem_q[sq_wp_q] <= drtol2_snack;
        sq_wp_q           <= ~sq_wp_q;
      end
      if (sq_pop_s) begin
        sq_rp_q <= ~sq_rp_q;
      end
      sq_cnt_q   <= sq_cnt_d;
      sq_retry_q <= (sq_cnt_d == QFULL);
    end
  end

  // Head-of-line routing: only the head's target ever sees valid.
  assign sq_head_s              = sq_mem_q[sq_rp_q];
  assign drtol2_snack_l2_valid  = sq_ne_s & ~sq_head_s[0];
  assign drtol2_snack_tlb_valid = sq_ne_s &  sq_head_s[0];
  assign drtol2_snack_l2        = sq_head_s;
  assign drtol2_snack_tlb       = sq_head_s;
  assign drtol2_snack_retry     = sq_retry_q;
  assign sq_pop_s = (drtol2_snack_l2_valid  & ~drtol2_snack_l2_retry) |
                    (drtol2_snack_tlb_valid & ~drtol2_snack_tlb_retry);

endmodule

// File: doc/l2dr_req_arbiter.md
# l2dr_req_arbiter

Shares the single L2-to-directory request channel between the L2 cache and the L2TLB, and routes directory snack responses back to the right one. It sits inside the L2 at the directory boundary: the L2 pipeline and the L2TLB each present requests, and the block round-robin arbitrates them onto `l2todr_req`. The source is encoded in `nid[0]` (even = L2, odd = L2TLB), and incoming `drtol2_snack` is demultiplexed on that same bit. All channels use the codebase valid/retry handshake, with registered retry toward every producer.

## Interface
Parameters:
- `RR_INIT`, default 0: round-robin pointer value after reset. 0 means L2 was last granted, so L2TLB wins the first tie.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `l2todr_req_l2_valid`  in  1  L2 request valid.
- `l2todr_req_l2_retry`  out  1  L2 request retry.
- `l2todr_req_l2`  in  $bits(I_l2todr_req_type)  L2 request payload.
- `l2todr_req_tlb_valid`  in  1  L2TLB request valid.
- `l2todr_req_tlb_retry`  out  1  L2TLB request retry.
- `l2todr_req_tlb`  in  $bits(I_l2todr_req_type)  L2TLB request payload.
- `l2todr_req_valid`  out  1  merged request valid, toward the directory.
- `l2todr_req_retry`  in  1  directory retry.
- `l2todr_req`  out  $bits(I_l2todr_req_type)  merged request payload.
- `drtol2_snack_valid`  in  1  snack valid, from the directory.
- `drtol2_snack_retry`  out  1  snack retry.
- `drtol2_snack`  in  $bits(I_drtol2_snack_type)  snack payload.
- `drtol2_snack_l2_valid` / `_retry` / payload  out / in / out  1 / 1 / $bits(I_drtol2_snack_type)  snack toward the L2.
- `drtol2_snack_tlb_valid` / `_retry` / payload  out / in / out  1 / 1 / $bits(I_drtol2_snack_type)  snack toward the L2TLB.

## Operation
- **Transfer rule.** A transfer occurs when valid=1 and retry=0 in the same cycle.
  - A producer holds valid and payload stable until the transfer.
  - Retry may assert independently of valid.
- **Input queues.** There are two request queues, QL2 and QTLB, each 2 entries deep.
  - A producer's retry is registered and equals (count==2).
  - On enqueue, `nid[0]` is overwritten: 0 for QL2, 1 for QTLB. All other fields pass through unchanged.
- **Output selection.** `l2todr_req_valid` = QL2 nonempty OR QTLB nonempty. `l2todr_req` = head of the selected queue.
- **Selection state.** There are two states.
  - OPEN:
    - Exactly one queue nonempty: select that queue.
    - Both queues nonempty: select the queue not last granted, using pointer `last`.
    - If the output is retried, latch the selection and move to LOCKED.
    - On a transfer, pop the selected queue, set `last` to the popped source, and stay in OPEN.
  - LOCKED:
    - Keep the latched selection, even if the other queue fills.
    - On a transfer, pop, update `last`, and return to OPEN.
- **Snack path.** There is one 2-entry snack queue.
  - `drtol2_snack_retry` is registered and equals (count==2).
  - Head routing: `nid[0]`=0 goes to the L2 output, 1 goes to the L2TLB output. The non-target output's valid is held at 0.
  - The payload is forwarded unmodified to both outputs.
  - Routing is head-of-line: a retried head blocks the entry behind it, even if that entry targets the other consumer.
- **Simultaneous enqueue and pop.** Both in the same cycle on one queue is legal. Count stays the same and order is preserved.
- **Counters.** Queue counts are 2-bit, range 0..2. Write and read pointers are 1 bit and wrap.

## Timing
- **Reset.** `reset`=0 asynchronously clears:
  - all queues (count 0);
  - all `*_valid` outputs (0);
  - the selection state (OPEN), with `last`=RR_INIT.
- **Retry during and after reset.** While `reset`=0, every `*_retry` output is 1. Retries drop to 0 on the first `clk` edge after release.
- **Reset mid-operation.** Queued entries are discarded; nothing is replayed.
- **Latency.** An entry accepted at edge N is visible on the output during cycle N+1 (1-cycle latency).
- **Throughput.** One request and one snack per cycle are sustained with no backpressure. Fairness gives alternate grants when both sources stream.
- **No combinational paths.** There is no combinational path from any input valid to any retry output, or from downstream retry to upstream retry.
- **Full queue.** A producer asserting valid while its retry=1 is not enqueued. Its data must remain held.

## Test plan
- **Single L2 request.** L2 request with nid=0x6, `l2id`=3, directory retry=0 → `l2todr_req_valid`=1 next cycle with nid=0x6, `l2id`=3. QL2 is empty afterwards.
- **Single L2TLB request.** L2TLB request with nid=0x6 → output nid=0x7. An L2 request with nid=0x5 → output nid=0x4.
- **Fair alternation.** Both sources stream 4 requests each from reset with RR_INIT=0 → output order TLB, L2, TLB, L2, …, 8 transfers in 8 cycles.
- **Backpressure.** Directory retry=1 for 5 cycles with both queues loaded → the output payload is constant across those cycles. Both producer retries are 1 once count==2. All 4 entries drain in order after release.
- **Snack routing.** Snacks with nid=2, then 3 → `drtol2_snack_l2_valid` in cycle 1, `drtol2_snack_tlb_valid` in cycle 2. With `drtol2_snack_l2_retry`=1, the nid=3 snack is blocked and `drtol2_snack_retry` goes to 1 after 2 entries.
- **Mid-traffic reset.** Reset asserted with 2 entries queued → all valids drop to 0 asynchronously and all retries are 1. After release, counts are 0 and the first grant follows RR_INIT.
